// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads IM, and queues fetched
// words in a 2-entry FIFO for decode; handles redirects and sticky fetch faults.
module imem_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  output logic [12:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  logic [31:0] fpc_r, fpc_n_s;
  logic [1:0]  count_r, count_n_s;
  logic        valid_r, valid_n_s;
  logic [31:0] pc0_r, pc0_n_s, word0_r, word0_n_s;
  logic [31:0] pc1_r, pc1_n_s, word1_r, word1_n_s;
  logic        fault_r, fault_n_s;
  logic [31:0] fault_pc_r, fault_pc_n_s;
  logic        legal_s, pop_s, can_push_s, push_s;

  // Fetch qualification: legality of the current PC and handshake terms
  always_comb begin
    legal_s    = (fpc_r >= IM_BASE) && (fpc_r <= IM_LIMIT) && (fpc_r[1:0] == 2'b00);
    pop_s      = valid_r && inst_ready;
    can_push_s = !fault_r && ((count_r != 2'd2) || pop_s);
    push_s     = !redirect && can_push_s && legal_s;
  end

  // Next-state for PC, queue slots, count and fault tracking
  always_comb begin
    fpc_n_s      = fpc_r;
    count_n_s    = count_r;
    pc0_n_s      = pc0_r;
    word0_n_s    = word0_r;
    pc1_n_s      = pc1_r;
    word1_n_s    = word1_r;
    fault_n_s    = fault_r;
    fault_pc_n_s = fault_pc_r;
    if (redirect) begin
      fpc_n_s   = redirect_pc;
      count_n_s = 2'd0;
      fault_n_s = 1'b0;
      pc0_n_s   = 32'd0;
      word0_n_s = 32'd0;
      pc1_n_s   = 32'd0;
      word1_n_s = 32'd0;
    end else begin
      // Slot 0 is always the head; a pop shifts slot 1 forward.
      if (pop_s) begin
        pc0_n_s   = pc1_r;
        word0_n_s = word1_r;
      end else begin
        pc0_n_s   = pc0_r;
        word0_n_s = word0_r;
      end
      if (push_s) begin
        if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
          pc0_n_s   = fpc_r;
          word0_n_s = im_data;
        end else begin
          pc1_n_s   = fpc_r;
          word1_n_s = im_data;
        end
        fpc_n_s = fpc_r + 32'd4;
      end else if (can_push_s && !legal_s) begin
        fault_n_s    = 1'b1;
        fault_pc_n_s = fpc_r;
      end else begin
        fpc_n_s = fpc_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_n_s = count_r + 2'd1;
        2'b01:   count_n_s = count_r - 2'd1;
        default: count_n_s = count_r;
      endcase
    end
    valid_n_s = (count_n_s != 2'd0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_r      <= PC_RESET;
      count_r    <= 2'd0;
      valid_r    <= 1'b0;
      pc0_r      <= 32'd0;
      word0_r    <= 32'd0;
      pc1_r      <= 32'd0;
      word1_r    <= 32'd0;
      fault_r    <= 1'b0;
      fault_pc_r <= 32'd0;
    end else begin
      fpc_r      <= fpc_n_s;
      count_r    <= count_n_s;
      valid_r    <= valid_n_s;
      pc0_r      <= pc0_n_s;
      word0_r    <= word0_n_s;
      pc1_r      <= pc1_n_s;
      word1_r    <= word1_n_s;
      fault_r    <= fault_n_s;
      fault_pc_r <= fault_pc_n_s;
    end
  end

  assign im_addr    = fpc_r[14:2];
  assign inst_valid = valid_r;
  assign inst       = word0_r;
  assign inst_pc    = pc0_r;
  assign fault      = fault_r;
  assign fault_pc   = fault_pc_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; IM model returns each word's own byte address.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] im_addr;
  logic [31:0] im_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int vectors = 0;
  int miscompares = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .im_addr(im_addr), .im_data(im_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  assign im_data = {17'd0, im_addr, 2'b00};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = rdy;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    reset = 1'b1;
    vectors++;
    if ({inst_valid, inst, inst_pc, fault, fault_pc} !== {1'b0, 32'd0, 32'd0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b inst=%h pc=%h fault=%0b fpc=%h, want all zero",
               inst_valid, inst, inst_pc, fault, fault_pc);
    end
    vectors++;
    if (im_addr !== 13'h0c00) begin
      miscompares++;
      $display("FAIL reset_im_addr: got %h want 0c00", im_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 32'h0000_3000 + 32'(i * 4);
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc, exp_pc}) begin
        miscompares++;
        $display("FAIL stream[%0d]: valid=%0b pc=%h inst=%h want valid=1 pc=inst=%h",
                 i, inst_valid, inst_pc, inst, exp_pc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0000_3000, 32'h0000_3000}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%0b pc=%h inst=%h want head 3000", i, inst_valid, inst_pc, inst);
      end
      if (i >= 1) begin
        vectors++;
        if (im_addr !== 13'h0c02) begin
          miscompares++;
          $display("FAIL bp_im_addr[%0d]: got %h want 0c02", i, im_addr);
        end
      end
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0000_3000 + 32'(i * 4);
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc, exp_pc}) begin
        miscompares++;
        $display("FAIL bp_release[%0d]: valid=%0b pc=%h inst=%h want %h", i, inst_valid, inst_pc, inst, exp_pc);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step(); step();
    vectors++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h0000_3000}) begin
      miscompares++;
      $display("FAIL redir_pre: valid=%0b pc=%h want head 3000", inst_valid, inst_pc);
    end
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3100;
    step();
    redirect = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_bubble: valid=%0b want 0", inst_valid);
    end
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0000_3100, 32'h0000_3100}) begin
      miscompares++;
      $display("FAIL redir_target: valid=%0b pc=%h inst=%h want 3100", inst_valid, inst_pc, inst);
    end
    step();
    vectors++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h0000_3104}) begin
      miscompares++;
      $display("FAIL redir_next: valid=%0b pc=%h want 3104", inst_valid, inst_pc);
    end
  endtask

  task automatic test_top_boundary();
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_6ff8;
    step();
    redirect = 1'b0;
    vectors++;
    if ({inst_valid, im_addr} !== {1'b0, 13'h1bfe}) begin
      miscompares++;
      $display("FAIL top_redir: valid=%0b im_addr=%h want 0/1bfe", inst_valid, im_addr);
    end
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst, fault} !== {1'b1, 32'h0000_6ff8, 32'h0000_6ff8, 1'b0}) begin
      miscompares++;
      $display("FAIL top_6ff8: valid=%0b pc=%h inst=%h fault=%0b", inst_valid, inst_pc, inst, fault);
    end
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst, fault} !== {1'b1, 32'h0000_6ffc, 32'h0000_6ffc, 1'b0}) begin
      miscompares++;
      $display("FAIL top_6ffc: valid=%0b pc=%h inst=%h fault=%0b", inst_valid, inst_pc, inst, fault);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({inst_valid, fault, fault_pc, im_addr} !== {1'b0, 1'b1, 32'h0000_7000, 13'h1c00}) begin
        miscompares++;
        $display("FAIL top_fault[%0d]: valid=%0b fault=%0b fault_pc=%h im_addr=%h want 0/1/7000/1c00",
                 i, inst_valid, fault, fault_pc, im_addr);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    redirect = 1'b0;
    vectors++;
    if ({inst_valid, fault} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL top_clear: valid=%0b fault=%0b want 0/0", inst_valid, fault);
    end
    step();
    vectors++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h0000_3000}) begin
      miscompares++;
      $display("FAIL top_resume: valid=%0b pc=%h want 3000", inst_valid, inst_pc);
    end
  endtask

  task automatic test_misaligned();
    do_reset(1'b1);
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_3002;
    step();
    redirect = 1'b0;
    vectors++;
    if ({inst_valid, fault} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mis_n1: valid=%0b fault=%0b want 0/0", inst_valid, fault);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({inst_valid, fault, fault_pc, im_addr} !== {1'b0, 1'b1, 32'h0000_3002, 13'h0c00}) begin
        miscompares++;
        $display("FAIL mis_fault[%0d]: valid=%0b fault=%0b fault_pc=%h im_addr=%h want 0/1/3002/0c00",
                 i, inst_valid, fault, fault_pc, im_addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 32'h0000_6ffc;
    step();
    redirect = 1'b0;
    step(); step();
    vectors++;
    if ({inst_valid, inst_pc, fault, fault_pc} !== {1'b1, 32'h0000_6ffc, 1'b1, 32'h0000_7000}) begin
      miscompares++;
      $display("FAIL mid_pre: valid=%0b pc=%h fault=%0b fault_pc=%h want 1/6ffc/1/7000",
               inst_valid, inst_pc, fault, fault_pc);
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({inst_valid, inst, inst_pc, fault, fault_pc, im_addr} !==
        {1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 13'h0c00}) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%0b inst=%h pc=%h fault=%0b fault_pc=%h im_addr=%h want reset values",
               inst_valid, inst, inst_pc, fault, fault_pc, im_addr);
    end
    reset = 1'b0; inst_ready = 1'b1;
    step();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0000_3000, 32'h0000_3000}) begin
      miscompares++;
      $display("FAIL mid_restart: valid=%0b pc=%h inst=%h want 3000", inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_top_boundary();
    test_misaligned();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded 50000 time units, want completion");
    $fatal(1);
  end

endmodule
